// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory responder: FSM state encoding,
// parameter defaults, the wait counter width and the alignment rule.
package dmem_pkg;

    // Default number of 32-bit words in the data array (power of two)
    localparam int DMEM_DEPTH_WORDS_DEFAULT = 1024;

    // Default number of extra cycles between request capture and response
    localparam int DMEM_WAIT_STATES_DEFAULT = 2;

    // Wait counter width, enough for 0..15 wait states
    localparam int DMEM_CNT_W = 4;

    // Access sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    // Full-word accesses must sit on a word boundary and half-word lane
    // pairs must sit on a half-word boundary; single bytes always fit.
    function automatic logic dmemIsMisaligned(input logic [1:0] addrLo,
                                              input logic [3:0] be);
        logic wordBad;
        logic halfBad;
        wordBad = (be == 4'b1111) && (addrLo != 2'b00);
        halfBad = ((be == 4'b0011) || (be == 4'b1100)) && addrLo[0];
        return wordBad || halfBad;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// Word-organised RAM with synchronous byte-lane writes and a registered
// synchronous read port. The read register clears on reset and holds its
// value whenever no read is requested; the storage itself is never cleared.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS_DEFAULT,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             i_wrEn,
    input  logic             i_rdEn,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    input  logic [3:0]       i_be,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Byte-lane write: only lanes with their enable set are updated
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read word, cleared by reset and held between loads
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_rdata <= '0;
        end else if (i_rdEn) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Multi-cycle data-memory responder for the MEM stage of the core. A request
// seen in IDLE is captured, held for WAIT_STATES cycles, and completed in
// RESP where resp_valid pulses with the registered read word. stall holds the
// pipeline from the request cycle until the response cycle.
//
// The RAM access is issued on the clock edge that enters RESP, so the read
// word and the completion pulse are both visible during the RESP cycle. When
// WAIT_STATES is 0 that edge is also the capture edge, so the access takes its
// operands straight from the inputs instead of the capture registers.
//
// Optional build macro: DMEM_MISALIGN_CHK_EN
//   defined   - misaligned accesses are flagged on misalign (with resp_valid);
//               a misaligned store is dropped, a misaligned load leaves rdata
//               untouched.
//   undefined - misalign is tied low and every access uses the word index.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS_DEFAULT,
    parameter int WAIT_STATES = DMEM_WAIT_STATES_DEFAULT
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        req_valid,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        resp_valid,
    output logic        stall,
    output logic        misalign
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LOW_W = IDX_W + 2;
    localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(WAIT_STATES);

    dmem_state_t           r_state;
    dmem_state_t           w_stateNext;
    logic [DMEM_CNT_W-1:0] r_cnt;
    logic [DMEM_CNT_W-1:0] w_cntNext;

    logic [LOW_W-1:0]      r_addr;
    logic [31:0]           r_wdata;
    logic                  r_we;
    logic [3:0]            r_be;

    logic                  r_respValid;
    logic                  r_misalign;

    logic                  w_fromInputs;
    logic [LOW_W-1:0]      w_accAddr;
    logic [31:0]           w_accWdata;
    logic                  w_accWe;
    logic [3:0]            w_accBe;
    logic                  w_doAccess;
    logic                  w_misalign;
    logic                  w_wrEn;
    logic                  w_rdEn;
    logic                  w_unusedBits;

    // State and wait counter register, cleared to IDLE/0 by reset
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Next-state and counter logic for the IDLE -> WAIT -> RESP sequence
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_cntNext   = CNT_LOAD;
                    w_stateNext = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt != '0) begin
                    w_cntNext = r_cnt - 1'b1;
                end
                if (r_cnt <= DMEM_CNT_W'(1)) begin
                    w_stateNext = ST_RESP;
                end
            end
            ST_RESP: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    // Capture the request operands once, so later input changes are ignored
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
        end else if ((r_state == ST_IDLE) && req_valid) begin
            r_addr  <= addr[LOW_W-1:0];
            r_wdata <= wdata;
            r_we    <= we;
            r_be    <= byte_en;
        end
    end

    assign w_fromInputs = (r_state == ST_IDLE);
    assign w_accAddr    = w_fromInputs ? addr[LOW_W-1:0] : r_addr;
    assign w_accWdata   = w_fromInputs ? wdata           : r_wdata;
    assign w_accWe      = w_fromInputs ? we              : r_we;
    assign w_accBe      = w_fromInputs ? byte_en         : r_be;

    // Reset on the completing edge cancels the access, so no partial write
    assign w_doAccess = clr_n && (w_stateNext == ST_RESP);

`ifdef DMEM_MISALIGN_CHK_EN
    assign w_misalign = dmemIsMisaligned(w_accAddr[1:0], w_accBe);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_wrEn = w_doAccess &&  w_accWe && !w_misalign;
    assign w_rdEn = w_doAccess && !w_accWe && !w_misalign;

    // Upper address bits alias onto the array and are intentionally dropped
    assign w_unusedBits = ^{addr[31:LOW_W], w_accAddr[1:0]};

    // Completion pulse and misalignment flag, both visible during RESP
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_respValid <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_respValid <= w_doAccess;
            r_misalign  <= w_doAccess && w_misalign;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .clr_n   (clr_n),
        .i_wrEn  (w_wrEn),
        .i_rdEn  (w_rdEn),
        .i_idx   (w_accAddr[LOW_W-1:2]),
        .i_wdata (w_accWdata),
        .i_be    (w_accBe),
        .o_rdata (rdata)
    );

    assign stall      = ((r_state == ST_IDLE) && req_valid) || (r_state == ST_WAIT);
    assign resp_valid = r_respValid;
    assign misalign   = r_misalign;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words in the data array (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 2, meaning extra cycles between request capture and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port clr_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  MEM-stage access request (load or store) present.
REQ-006 SHALL have port addr  input  32  byte address (core ALUResultM).
REQ-007 SHALL have port wdata  input  32  store data (core WriteDataM), lanes already positioned.
REQ-008 SHALL have port we  input  1  store when 1, load when 0 (core MemWriteM).
REQ-009 SHALL have port byte_en  input  4  write lane enables (core byteEnable).
REQ-010 SHALL have port rdata  output  32  registered full read word (to core loadext RD_data).
REQ-011 SHALL have port resp_valid  output  1  one-cycle pulse: access complete, rdata valid.
REQ-012 SHALL have port stall  output  1  to hazard unit; holds IF/ID/EX/MEM while access pending.
REQ-013 SHALL have port misalign  output  1  one-cycle pulse with resp_valid on misaligned access.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL, in IDLE with req_valid=1, capture addr/wdata/we/byte_en, load wait counter with WAIT_STATES, go to WAIT (or to RESP if WAIT_STATES=0).
REQ-016 SHALL, in WAIT, decrement counter each cycle and go to RESP in the cycle after counter reaches 1.
REQ-017 SHALL, in RESP, perform the captured write (lanes with byte_en=1 only) or register the addressed word into rdata, pulse resp_valid, then go to IDLE unconditionally.
REQ-018 SHALL drive stall combinationally = (IDLE and req_valid) or WAIT; stall=0 in RESP, so latency is WAIT_STATES+1 cycles from request to resp_valid.
REQ-019 SHALL ignore input changes after capture until return to IDLE.
REQ-020 SHALL index the array by addr[log2(DEPTH_WORDS)+1:2]; upper bits ignored (aliasing, no fault).
REQ-021 SHALL hold rdata at last read value through stores and idle cycles.
REQ-022 SHALL treat byte_en=0000 with we=1 as a completed no-op store.

Reset
REQ-023 SHALL, on clr_n=0 at a clock edge, force IDLE, counter=0, rdata=0, resp_valid=0, misalign=0; stall follows REQ-018 from IDLE.
REQ-024 SHALL discard any pending access on reset mid-operation; no partial write performed.
REQ-025 SHALL NOT reset array contents.

Configuration
REQ-026 SHALL, with DMEM_MISALIGN_CHK_EN defined, flag misaligned = (byte_en=1111 and addr[1:0]!=0) or (byte_en in {0011,1100} and addr[0]=1); a misaligned store is suppressed, a misaligned load leaves rdata unchanged, misalign pulses in RESP.
REQ-027 SHALL, without DMEM_MISALIGN_CHK_EN, tie misalign=0 and perform every access on the word-aligned index.

Structure
REQ-028 SHALL place the FSM state enum and the DEPTH_WORDS/WAIT_STATES defaults in shared package dmem_pkg.
REQ-029 SHALL instantiate one sub-module dmem_array: word RAM, synchronous byte-lane write, synchronous read.

Verification
REQ-030 SHALL cover: store addr=0x10 wdata=0xDEADBEEF byte_en=1111, then load 0x10 -> rdata=0xDEADBEEF, resp_valid at cycle 3 after each request (WAIT_STATES=2), stall high cycles 0-2.
REQ-031 SHALL cover: word 0x20=0x11223344, sb wdata=0x0000AA00 byte_en=0010 at 0x21 -> load returns 0x1122AA44.
REQ-032 SHALL cover: WAIT_STATES=0 -> resp_valid one cycle after request, stall high exactly one cycle.
REQ-033 SHALL cover: clr_n low during WAIT of store to 0x30 (prior 0x0) -> IDLE next cycle, resp_valid never pulses, load 0x30 returns 0x0.
REQ-034 SHALL cover: DMEM_MISALIGN_CHK_EN defined, store byte_en=1111 at 0x42 -> misalign=1 with resp_valid, word 0x40 unchanged; undefined -> misalign=0, word 0x40 written.
